// File: rtl/loss_gradient_collector_pkg.sv
// Shared types and constants for the loss-gradient collector.
// Gradients are signed Q8.8: bit 15 is the sign, 8 integer bits and 8 fraction bits.
// Data passes through the collector unmodified, so no arithmetic helpers live here.
package loss_gradient_collector_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/loss_gradient_collector_grad_col_fifo.sv
// Single-column synchronous FIFO holding per-row gradient samples.
// Head data is read from registered storage and is visible as soon as the entry exists.
// The caller only pushes when there is room (or a pop happens in the same cycle) and only pops when non-empty.
module grad_col_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // One extra pointer bit separates "full" from "empty" when the indices match.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Pointer update; both may advance in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Sample storage; a push into the slot being popped overwrites it only after the read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/loss_gradient_collector.sv
// Deskews the two per-column loss-gradient streams into rows and hands them downstream.
// A row becomes valid the cycle after its later sample is pushed; rows pop on valid && ready.
// Inputs cannot be stalled: samples arriving with no room or beyond the batch are dropped and flagged.
module loss_gradient_collector
  import loss_gradient_collector_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ROWS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [ROWS_W-1:0] num_rows_in,
  input  logic [DATA_W-1:0] gradient_1_in,
  input  logic              valid_1_in,
  input  logic [DATA_W-1:0] gradient_2_in,
  input  logic              valid_2_in,
  output logic [DATA_W-1:0] row_1_out,
  output logic [DATA_W-1:0] row_2_out,
  output logic [ROWS_W-1:0] row_index_out,
  output logic              row_valid_out,
  input  logic              row_ready_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              overflow_err_out
);

  localparam logic [ROWS_W-1:0] ROW_ONE = ROWS_W'(1);

  state_t            state;
  state_t            state_next;
  logic [ROWS_W-1:0] num_rows;
  logic [ROWS_W-1:0] rows_emitted;
  logic [ROWS_W-1:0] emitted_next;
  logic [ROWS_W-1:0] accepted_1;
  logic [ROWS_W-1:0] accepted_2;
  logic              err;

  logic [DATA_W-1:0] head_1;
  logic [DATA_W-1:0] head_2;
  logic              full_1, full_2;
  logic              empty_1, empty_2;

  logic collecting;
  logic row_valid;
  logic pop;
  logic ok_1, ok_2;
  logic push_1, push_2;
  logic drop_1, drop_2;
  logic begin_batch;

  assign collecting  = (state == COLLECT);
  assign begin_batch = (state == IDLE) && start_in;
  assign row_valid   = !empty_1 && !empty_2;
  assign pop         = row_valid && row_ready_in;

  // A full FIFO still takes a sample when its head leaves in the same cycle.
  assign ok_1   = (!full_1 || pop) && (accepted_1 < num_rows);
  assign ok_2   = (!full_2 || pop) && (accepted_2 < num_rows);
  assign push_1 = collecting && valid_1_in && ok_1;
  assign push_2 = collecting && valid_2_in && ok_2;
  assign drop_1 = collecting && valid_1_in && !ok_1;
  assign drop_2 = collecting && valid_2_in && !ok_2;

  assign emitted_next = pop ? (rows_emitted + ROW_ONE) : rows_emitted;

  grad_col_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_col_1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push_1),
    .push_data (gradient_1_in),
    .pop       (pop),
    .head      (head_1),
    .full      (full_1),
    .empty     (empty_1)
  );

  grad_col_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_col_2 (
    .clk       (clk),
    .rst       (rst),
    .push      (push_2),
    .push_data (gradient_2_in),
    .pop       (pop),
    .head      (head_2),
    .full      (full_2),
    .empty     (empty_2)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state; the batch ends in the same cycle the final row is popped.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_in) state_next = COLLECT;
      COLLECT: if (emitted_next == num_rows) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Batch bookkeeping: row quota, per-column acceptance, emitted rows, sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_rows     <= '0;
      rows_emitted <= '0;
      accepted_1   <= '0;
      accepted_2   <= '0;
      err          <= 1'b0;
    end else if (begin_batch) begin
      num_rows     <= num_rows_in;
      rows_emitted <= '0;
      accepted_1   <= '0;
      accepted_2   <= '0;
      err          <= 1'b0;
    end else begin
      rows_emitted <= emitted_next;
      if (push_1) accepted_1 <= accepted_1 + ROW_ONE;
      if (push_2) accepted_2 <= accepted_2 + ROW_ONE;
      if (drop_1 || drop_2) err <= 1'b1;
    end
  end

  assign row_valid_out    = row_valid;
  assign row_1_out        = row_valid ? head_1 : '0;
  assign row_2_out        = row_valid ? head_2 : '0;
  assign row_index_out    = rows_emitted;
  assign busy_out         = collecting;
  assign done_out         = (state == DONE);
  assign overflow_err_out = err;

endmodule

// File: doc/loss_gradient_collector.md
Name: loss_gradient_collector

Overview:
- Sink end of the loss stage: consumes the two skewed per-column gradient streams produced by the loss unit (gradient + valid per column, no backpressure).
- Deskews them into row pairs, buffers up to DEPTH rows and hands complete rows to the unified-buffer writer over a valid/ready handshake.
- Counts rows against a programmed batch length and signals completion.

Parameters:
- DEPTH, 4, rows buffered per column FIFO (power of two, >= 2)
- ROWS_W, 8, width of row count and row index

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_in  in  1  pulse; latches num_rows_in, clears error, begins collection
- num_rows_in  in  ROWS_W  rows expected in this batch
- gradient_1_in  in  16  signed Q8.8 column-1 gradient
- valid_1_in  in  1  column-1 sample strobe
- gradient_2_in  in  16  signed Q8.8 column-2 gradient
- valid_2_in  in  1  column-2 sample strobe
- row_1_out  out  16  column-1 element of head row
- row_2_out  out  16  column-2 element of head row
- row_index_out  out  ROWS_W  index of head row within batch
- row_valid_out  out  1  head row available
- row_ready_in  in  1  downstream accepts head row
- busy_out  out  1  high in COLLECT
- done_out  out  1  one-cycle pulse at batch completion
- overflow_err_out  out  1  sticky: sample dropped (FIFO full or beyond num_rows)

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. While rst high, every output is 0, FIFOs are emptied, counters are zeroed and state is IDLE. Reset mid-batch discards all buffered rows with no done pulse.
- States: IDLE -> COLLECT on start_in. COLLECT -> DONE when rows_emitted == num_rows. DONE -> IDLE unconditionally after 1 cycle. done_out is high exactly in DONE.
- start_in with num_rows_in = 0: COLLECT is entered and exits on the next cycle, so done_out pulses 2 cycles after start.
- start_in is ignored outside IDLE.
- IDLE and DONE: valid_x_in is ignored. No push occurs and no error is raised.
- COLLECT push, per column independently: on valid_x_in, push gradient_x_in if the FIFO is not full and accepted_x < num_rows.
  - Otherwise the sample is dropped and overflow_err_out is set.
  - overflow_err_out is cleared only by rst or start_in.
- Push while full with a pop in the same cycle is accepted and the occupancy is unchanged.
- Arbitrary skew between columns is tolerated up to DEPTH rows.
- row_valid_out = both column FIFOs non-empty; combinational from the empty flags.
- row_1_out, row_2_out are the FIFO heads, read from registered storage. They are 0 when row_valid_out is low.
- Latency: row_valid_out rises the cycle after the later of the two samples of a row is pushed.
- Pop: row_valid_out && row_ready_in pops both FIFOs in the same cycle and increments rows_emitted, which is ROWS_W bits and drives row_index_out.
- row_1_out and row_2_out stay stable while row_valid_out is high and row_ready_in is low.
- Arithmetic: data passes through unmodified; no saturation or rounding.
- FIFO pointers use log2(DEPTH)+1 bits. Pointers wrap naturally, and full/empty are decoded from the MSB difference.

Decomposition:
- Shared package: DATA_W = 16, the collector state enum {IDLE, COLLECT, DONE}, and the Q8.8 format note.
- Sub-module grad_col_fifo: a single-column synchronous FIFO with parameters DATA_W and DEPTH, push/pop, head data, full and empty. It is instantiated twice.

Test Plan:
- Skewed batch: num_rows=3, ready=1.
  - Stimulus: column 1 valid at cycles 0,1,2 with 0x0100, 0x0200, 0xFF00; column 2 valid at cycles 1,2,3 with 0x0080, 0xFF80, 0x0000.
  - Required: rows (0x0100,0x0080), (0x0200,0xFF80), (0xFF00,0x0000) valid at cycles 2,3,4 with indices 0,1,2; done_out pulses once at cycle 5; no error.
- Backpressure: DEPTH=4, num_rows=4, ready=0 during all pushes.
  - Required: all 4 rows held; row_valid_out=1 with head stable; no error.
  - Then ready=1: rows drain in order on consecutive cycles, followed by the done pulse.
- Overflow:
  - 5 column-1 samples with ready=0 and DEPTH=4 -> 5th sample dropped, overflow_err_out=1 stays high; output shows only the first 4 rows.
  - num_rows=2 with 3 samples -> 3rd sample dropped and error set.
- Full push+pop: FIFOs full, ready=1 and a new pair pushed in the same cycle -> pair accepted, no error, order preserved.
- Zero-length batch: start_in with num_rows=0 -> done_out high exactly 2 cycles after start; row_valid_out never asserted.
- Reset mid-batch: rst for 1 cycle after 2 of 4 rows are pushed -> all outputs 0, no done pulse. A new start with num_rows=1 then completes normally with row_index_out=0.
